// File: rtl/udm_uart_pkg.sv
// Shared types and constants for the udm UART receive path.
package udm_uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_rx_state_t;

    // Smallest usable bit period; anything below leaves no room for a centre sample.
    localparam int unsigned MIN_DIV = 4;

endpackage

// File: rtl/udm_sync_bit.sv
// Two-flop synchroniser for a single asynchronous input bit.
module udm_sync_bit #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            meta <= RST_VAL;
            q_o  <= RST_VAL;
        end else begin
            meta <= d_i;
            q_o  <= meta;
        end
    end

endmodule

// File: rtl/udm_uart_rx.sv
// UART 8N1 receiver for the udm debug module: start-bit glitch rejection,
// centre sampling, stop-bit check and a valid/ready byte output.
module udm_uart_rx
    import udm_uart_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned DATA_BITS = 8
) (
    input  logic                 clk_i,
    input  logic                 arst_i,
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] clk_div_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 ferr_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    uart_rx_state_t         state_q, state_d;
    logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0]   div_q, div_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   done_q, done_d;
    logic                   ferr_d;
    logic                   rxs;
    logic                   cnt_zero;
    logic [DIV_WIDTH-1:0]   div_eff;
    logic [DIV_WIDTH-1:0]   reload;

    udm_sync_bit #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .arst_i(arst_i),
        .d_i   (rx_i),
        .q_o   (rxs)
    );

    assign div_eff  = (clk_div_i < DIV_WIDTH'(MIN_DIV)) ? DIV_WIDTH'(MIN_DIV) : clk_div_i;
    assign cnt_zero = (cnt_q == '0);
    assign reload   = div_q - DIV_WIDTH'(1);
    assign busy_o   = (state_q != IDLE);

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Divider is latched here so the half-bit count uses the new value.
                if (!rxs) begin
                    state_d = START;
                    div_d   = div_eff;
                    cnt_d   = (div_eff >> 1) - DIV_WIDTH'(1);
                end
            end
            START: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                        cnt_d   = reload;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            DATA: begin
                if (cnt_zero) begin
                    shreg_d = {rxs, shreg_q[DATA_BITS-1:1]};
                    cnt_d   = reload;
                    if (idx_q == IDX_W'(DATA_BITS - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            STOP: begin
                if (cnt_zero) begin
                    if (rxs) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = BREAK;
                        ferr_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - DIV_WIDTH'(1);
                end
            end
            BREAK: begin
                if (rxs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output register: shreg_q is untouched until the next frame reaches DATA.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            ferr_o    <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            ferr_o    <= ferr_d;
            overrun_o <= 1'b0;
            if (done_q) begin
                if (!valid_o || ready_i) begin
                    data_o  <= shreg_q;
                    valid_o <= 1'b1;
                end else begin
                    overrun_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end
        end
    end

endmodule
